// File: rtl/axis_video_tpg.sv
// AXI4-Stream video test pattern generator: bars, solid, checker and scrolling ramp,
// with backpressure, back-to-back frames and a completed-frame counter.
module axis_video_tpg #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int COMP_W      = 8,
    parameter int NUM_BARS    = 8,
    parameter int CHECK_SHIFT = 5,
    parameter int FCNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    input  logic [3*COMP_W-1:0]   i_solid_color,
    output logic [3*COMP_W-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic [FCNT_W-1:0]     o_frame_cnt,
    output logic                  o_busy
);
    localparam int PW    = 3 * COMP_W;
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int BAR_W = H_ACTIVE / NUM_BARS;

    localparam logic [XW-1:0] XLAST     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] YLAST     = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] BCNT_LAST = XW'(BAR_W - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(NUM_BARS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d, bcnt_q, bcnt_d;
    logic [YW-1:0]       y_q, y_d;
    logic [BW-1:0]       bidx_q, bidx_d;
    logic [1:0]          mode_q, mode_d;
    logic [PW-1:0]       color_q, color_d;
    logic [FCNT_W-1:0]   base_q, base_d, fcnt_q, fcnt_d;
    logic [PW-1:0]       tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic                busy_q, busy_d;

    logic                fire, start, chk_px;
    logic [2:0]          bar_c;
    logic [COMP_W-1:0]   ramp;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bcnt_d   = bcnt_q;
        bidx_d   = bidx_q;
        mode_d   = mode_q;
        color_d  = color_q;
        base_d   = base_q;
        fcnt_d   = fcnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        start    = 1'b0;
        fire     = tvalid_q && m_axis_tready;
        bar_c    = 3'd0;
        chk_px   = 1'b0;
        ramp     = '0;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    start  = 1'b1;
                    base_d = fcnt_q;
                end
            end
            ACTIVE: begin
                if (fire) begin
                    if (x_q == XLAST) begin
                        x_d    = '0;
                        bcnt_d = '0;
                        bidx_d = '0;
                        if (y_q == YLAST) begin
                            fcnt_d = fcnt_q + 1'b1;
                            if (i_enable) begin
                                start  = 1'b1;
                                base_d = fcnt_q + 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        // Last bar saturates and soaks up the H_ACTIVE % NUM_BARS remainder.
                        if (bcnt_q == BCNT_LAST && bidx_q != BIDX_LAST) begin
                            bcnt_d = '0;
                            bidx_d = bidx_q + 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            bcnt_d  = '0;
            bidx_d  = '0;
            mode_d  = i_mode;
            color_d = i_solid_color;
        end

        bar_c  = 3'd7 - 3'(bidx_d);
        chk_px = (|((x_d >> CHECK_SHIFT) & XW'(1))) ^ (|((y_d >> CHECK_SHIFT) & YW'(1)));
        ramp   = COMP_W'(x_d) + COMP_W'(base_d);

        // Output registers only move on a transfer or a frame start, so they hold under stall.
        if (fire || start) begin
            tvalid_d = (state_d == ACTIVE);
            tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
            tlast_d  = tvalid_d && (x_d == XLAST);
            busy_d   = (state_d == ACTIVE);
            tdata_d  = '0;
            if (tvalid_d) begin
                case (mode_d)
                    2'd0:    tdata_d = {{COMP_W{bar_c[1]}}, {COMP_W{bar_c[2]}}, {COMP_W{bar_c[0]}}};
                    2'd1:    tdata_d = color_d;
                    2'd2:    tdata_d = {PW{chk_px}};
                    default: tdata_d = {ramp, ramp, ramp};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bcnt_q   <= '0;
            bidx_q   <= '0;
            mode_q   <= '0;
            color_q  <= '0;
            base_q   <= '0;
            fcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bcnt_q   <= bcnt_d;
            bidx_q   <= bidx_d;
            mode_q   <= mode_d;
            color_q  <= color_d;
            base_q   <= base_d;
            fcnt_q   <= fcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign o_frame_cnt   = fcnt_q;
    assign o_busy        = busy_q;
endmodule

// File: tb/tb_axis_video_tpg.sv
// Bench for axis_video_tpg on a 16x4 frame: vector table of whole frames plus
// sequences for back-to-back frames, mid-frame changes and mid-frame reset.
module tb_axis_video_tpg;
    localparam int H = 16, V = 4, NB = 4, CS = 1, C = 8, FW = 16;
    localparam int FB = H * V;

    logic          clk, resetn, i_enable, m_axis_tready;
    logic [1:0]    i_mode;
    logic [23:0]   i_solid_color, m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast, o_busy;
    logic [FW-1:0] o_frame_cnt;

    axis_video_tpg #(.H_ACTIVE(H), .V_ACTIVE(V), .COMP_W(C), .NUM_BARS(NB),
                     .CHECK_SHIFT(CS), .FCNT_W(FW)) dut (
        .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_mode(i_mode),
        .i_solid_color(i_solid_color), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .o_frame_cnt(o_frame_cnt), .o_busy(o_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic        u;
        logic        l;
        logic [15:0] f;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] color;
        bit          rnd;
        logic [23:0] first_d;
        logic [23:0] last_d;
        logic [15:0] fcnt;
    } vec_t;

    beat_t q[$];
    vec_t  tbl[5];
    int    checks = 0, failures = 0;
    int    fcnt_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference pixel straight from the pattern rules.
    function automatic logic [23:0] exp_pix(input int m, input logic [23:0] col,
                                            input int x, input int y, input int base);
        logic [23:0] r;
        int i;
        logic [7:0] v;
        r = 24'h0;
        case (m)
            0: begin
                i = x / (H / NB);
                if (i > NB - 1) i = NB - 1;
                case (i % 8)
                    0: r = 24'hFFFFFF;
                    1: r = 24'hFFFF00;
                    2: r = 24'h00FFFF;
                    3: r = 24'h00FF00;
                    4: r = 24'hFF00FF;
                    5: r = 24'hFF0000;
                    6: r = 24'h0000FF;
                    default: r = 24'h000000;
                endcase
            end
            1: r = col;
            2: r = ((((x >> CS) & 1) ^ ((y >> CS) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                v = 8'((x + base) % 256);
                r = {v, v, v};
            end
        endcase
        return r;
    endfunction

    // Collects n accepted beats; checks stall stability; applies a change at beat chg_at.
    task automatic run(input int n, input bit rnd, input bit en_hold, input int chg_at,
                       input logic [1:0] m2, input logic [23:0] c2, input bit en2);
        int cyc = 0, got = 0;
        bit stall = 0, rdy;
        logic [23:0] pd;
        logic pu, pl;
        beat_t b;
        pd = '0; pu = 0; pl = 0;
        q.delete();
        while (got < n && cyc < n * 4 + 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) i_enable = en_hold;
            if (stall)
                chk("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                    {1'b1, pu, pl, pd});
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = rdy;
            if (m_axis_tvalid && rdy) begin
                b.d = m_axis_tdata; b.u = m_axis_tuser; b.l = m_axis_tlast;
                b.f = o_frame_cnt;  b.cyc = cyc;
                q.push_back(b);
                got++;
                if (got == chg_at) begin
                    i_mode = m2; i_solid_color = c2; i_enable = en2;
                end
            end
            stall = m_axis_tvalid && !rdy;
            pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
        end
        chk("beat_count", 64'(got), 64'(n));
        m_axis_tready = 1'b1;
    endtask

    task automatic check_frames(input int nfr, input int m, input logic [23:0] col, input int base);
        int p, x, y;
        for (int k = 0; k < nfr * FB && k < q.size(); k++) begin
            p = k % FB; x = p % H; y = p / H;
            chk($sformatf("beat%0d", k), {q[k].d, q[k].u, q[k].l},
                {exp_pix(m, col, x, y, base + k / FB), 1'(x == 0 && y == 0), 1'(x == H - 1)});
        end
    endtask

    task automatic check_idle(input string name, input int fc);
        @(posedge clk); #1;
        chk({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({name, "_busy"}, 64'(o_busy), 64'd0);
        chk({name, "_fcnt"}, 64'(o_frame_cnt), 64'(fc));
    endtask

    initial begin
        bit gap;
        tbl[0] = '{2'd0, 24'h000000, 1'b0, 24'hFFFFFF, 24'h00FF00, 16'd4};
        tbl[1] = '{2'd0, 24'h000000, 1'b1, 24'hFFFFFF, 24'h00FF00, 16'd5};
        tbl[2] = '{2'd1, 24'h123456, 1'b1, 24'h123456, 24'h123456, 16'd6};
        tbl[3] = '{2'd2, 24'h000000, 1'b1, 24'h000000, 24'h000000, 16'd7};
        tbl[4] = '{2'd3, 24'h000000, 1'b0, 24'h070707, 24'h161616, 16'd8};

        resetn = 0; i_enable = 0; i_mode = 0; i_solid_color = 0; m_axis_tready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, o_busy, m_axis_tdata},
            64'd0);
        chk("rst_fcnt", 64'(o_frame_cnt), 64'd0);
        resetn = 1;
        @(posedge clk); #1;
        chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);

        // Back-to-back ramp frames; enable drops inside the third frame.
        i_mode = 3; i_enable = 1;
        run(3 * FB, 0, 1, 2 * FB + 10, 2'd3, 24'h0, 0);
        chk("b2b_latency", 64'(q[0].cyc), 64'd1);
        check_frames(3, 3, 24'h0, 0);
        gap = 0;
        for (int k = 0; k < q.size(); k++) if (q[k].cyc != q[0].cyc + k) gap = 1;
        chk("b2b_gap", 64'(gap), 64'd0);
        chk("b2b_fcnt1", 64'(q[FB].f), 64'd1);
        chk("b2b_fcnt2", 64'(q[2 * FB].f), 64'd2);
        check_idle("b2b_end", 3);
        fcnt_model = 3;

        for (int r = 0; r < 5; r++) begin
            i_mode = tbl[r].mode; i_solid_color = tbl[r].color; i_enable = 1;
            run(FB, tbl[r].rnd, 0, 0, 2'd0, 24'h0, 0);
            check_frames(1, int'(tbl[r].mode), tbl[r].color, fcnt_model);
            chk($sformatf("row%0d_first", r), 64'(q[0].d), 64'(tbl[r].first_d));
            chk($sformatf("row%0d_last", r), 64'(q[FB - 1].d), 64'(tbl[r].last_d));
            check_idle($sformatf("row%0d", r), int'(tbl[r].fcnt));
            fcnt_model++;
        end

        // Mode/colour change and enable drop mid-frame must not affect the current frame.
        i_mode = 1; i_solid_color = 24'hABCDEF; i_enable = 1;
        run(FB, 1, 1, 10, 2'd0, 24'h0F0F0F, 0);
        check_frames(1, 1, 24'hABCDEF, fcnt_model);
        fcnt_model++;
        check_idle("midchg", fcnt_model);

        // Reset mid-frame, then restart from (0,0).
        i_mode = 2; i_enable = 1;
        run(20, 0, 0, 0, 2'd0, 24'h0, 0);
        chk("mid_busy", 64'(o_busy), 64'd1);
        resetn = 0;
        @(posedge clk); #1;
        chk("midrst_outputs", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, o_busy}, 64'd0);
        chk("midrst_fcnt", 64'(o_frame_cnt), 64'd0);
        resetn = 1; i_mode = 0; i_enable = 1;
        run(FB, 0, 0, 0, 2'd0, 24'h0, 0);
        chk("restart_latency", 64'(q[0].cyc), 64'd1);
        check_frames(1, 0, 24'h0, 0);
        check_idle("restart", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
